// File: rtl/bsg_adder_wallace_tree_sum_pkg.sv
// Shared types and helpers for the streaming Wallace-tree summer.
package bsg_adder_wallace_tree_sum_pkg;

  // Controller states: collect operands, reduce one batch, present the sum.
  typedef enum logic [1:0] {
    eFill   = 2'd0,
    eReduce = 2'd1,
    eDone   = 2'd2
  } state_e;

  // Upper bound on the batch size; sizes slot-index arithmetic.
  localparam int max_capacity = 32;

  // clog2 that never returns 0, so a 1-entry index still gets one bit.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Batch sizes the tree and pointer logic are built for.
  function automatic bit capacity_legal(input int c);
    return (c == 8) || (c == 16) || (c == 32);
  endfunction

endpackage

// File: rtl/bsg_adder_wallace_tree.sv
// Carry-save (Wallace) reduction of capacity_p operands down to two rows.
// resA_o + resB_o equals the sum of all operands modulo 2^width_p.
module bsg_adder_wallace_tree
  import bsg_adder_wallace_tree_sum_pkg::*;
#(
  parameter int width_p    = 32,
  parameter int capacity_p = 8
) (
  input  logic [capacity_p-1:0][width_p-1:0] ops_i,
  output logic [width_p-1:0]                 resA_o,
  output logic [width_p-1:0]                 resB_o
);

  localparam int idx_w = safe_clog2(capacity_p);

  // Number of 3:2 compressor levels needed to reach two rows.
  function automatic int num_levels(input int n);
    int c = 0;
    int m = n;
    for (int k = 0; k < 32; k++) begin
      if (m > 2) begin
        m = m - m / 3;
        c++;
      end
    end
    return c;
  endfunction

  localparam int levels_lp = num_levels(capacity_p);

  logic [width_p-1:0] cur [capacity_p];
  logic [width_p-1:0] nxt [capacity_p];
  int rows_n;
  int grp_n;
  int rem_n;

  // Each level groups rows in threes: sum row first, carry rows next, leftovers passed on.
  always_comb begin
    for (int r = 0; r < capacity_p; r++) begin
      cur[idx_w'(r)] = ops_i[r];
      nxt[idx_w'(r)] = '0;
    end
    rows_n = capacity_p;
    grp_n  = 0;
    rem_n  = 0;
    for (int l = 0; l < levels_lp; l++) begin
      grp_n = rows_n / 3;
      rem_n = rows_n - 3 * grp_n;
      for (int r = 0; r < capacity_p; r++) begin
        if (r < grp_n) begin
          nxt[idx_w'(r)] = cur[idx_w'(3*r)] ^ cur[idx_w'(3*r+1)] ^ cur[idx_w'(3*r+2)];
        end else if (r < 2 * grp_n) begin
          nxt[idx_w'(r)] = ((cur[idx_w'(3*(r-grp_n))]   & cur[idx_w'(3*(r-grp_n)+1)]) |
                            (cur[idx_w'(3*(r-grp_n))]   & cur[idx_w'(3*(r-grp_n)+2)]) |
                            (cur[idx_w'(3*(r-grp_n)+1)] & cur[idx_w'(3*(r-grp_n)+2)])) << 1;
        end else if (r < 2 * grp_n + rem_n) begin
          nxt[idx_w'(r)] = cur[idx_w'(3*grp_n + r - 2*grp_n)];
        end else begin
          nxt[idx_w'(r)] = '0;
        end
      end
      for (int r = 0; r < capacity_p; r++) begin
        cur[idx_w'(r)] = nxt[idx_w'(r)];
      end
      rows_n = 2 * grp_n + rem_n;
    end
    resA_o = cur[0];
    resB_o = cur[1];
  end

endmodule

// File: rtl/bsg_adder_wallace_tree_sum_seq.sv
// Streaming multi-operand summer: batches operands into a slot buffer,
// reduces each batch through a Wallace tree and accumulates the result.
module bsg_adder_wallace_tree_sum_seq
  import bsg_adder_wallace_tree_sum_pkg::*;
#(
  parameter int width_p       = 32,
  parameter int capacity_p    = 8,
  parameter int count_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic [width_p-1:0]       data_i,
  input  logic                     last_i,
  output logic                     ready_o,
  output logic                     v_o,
  output logic [width_p-1:0]       sum_o,
  output logic [count_width_p-1:0] count_o,
  input  logic                     yumi_i
);

  localparam int ptr_width = safe_clog2(capacity_p);

  if (!capacity_legal(capacity_p)) begin : g_bad_capacity
    $error("capacity_p must be 8, 16 or 32");
  end

  state_e                          state_q;
  logic [width_p-1:0]              slots_q [capacity_p];
  logic [capacity_p-1:0][width_p-1:0] tree_ops;
  logic [ptr_width-1:0]            ptr_q;
  logic [width_p-1:0]              acc_q;
  logic [count_width_p-1:0]        count_q;
  logic                            last_q;
  logic [width_p-1:0]              res_a;
  logic [width_p-1:0]              res_b;
  logic                            accept;
  logic                            batch_end;

  assign accept    = v_i & ready_o;
  assign batch_end = last_i | (ptr_q == ptr_width'(capacity_p - 1));

  for (genvar gi = 0; gi < capacity_p; gi++) begin : g_pack
    assign tree_ops[gi] = slots_q[gi];
  end

  bsg_adder_wallace_tree #(
    .width_p   (width_p),
    .capacity_p(capacity_p)
  ) u_tree (
    .ops_i (tree_ops),
    .resA_o(res_a),
    .resB_o(res_b)
  );

  // Slot buffer: written by accepted beats, cleared once its batch is reduced.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < capacity_p; i++) slots_q[i] <= '0;
    end else if (state_q == eReduce) begin
      for (int i = 0; i < capacity_p; i++) slots_q[i] <= '0;
    end else if (accept) begin
      slots_q[ptr_q] <= data_i;
    end
  end

  // Controller: fill pointer, running count, accumulator and state sequencing.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= eFill;
      ptr_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        eFill: begin
          if (accept) begin
            ptr_q <= ptr_q + ptr_width'(1);
            if (count_q != {count_width_p{1'b1}}) count_q <= count_q + count_width_p'(1);
            if (batch_end) begin
              state_q <= eReduce;
              last_q  <= last_i;
            end
          end
        end
        eReduce: begin
          acc_q   <= acc_q + res_a + res_b;
          ptr_q   <= '0;
          state_q <= last_q ? eDone : eFill;
        end
        eDone: begin
          if (yumi_i) begin
            acc_q   <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
            state_q <= eFill;
          end
        end
        default: state_q <= eFill;
      endcase
    end
  end

  assign ready_o = (state_q == eFill);
  assign v_o     = (state_q == eDone);
  assign sum_o   = acc_q;
  assign count_o = count_q;

`ifndef SYNTHESIS
  // The consumer may only take a sum that is being offered.
  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o));
`endif

endmodule

// File: tb/tb_bsg_adder_wallace_tree_sum_seq.sv
// Directed bench for the streaming Wallace-tree summer (three configurations).
module tb_bsg_adder_wallace_tree_sum_seq;

  logic clk = 1'b0;
  logic rst;
  logic v, last, yumi;
  logic [15:0] data;
  int sel;

  logic ready_a, vo_a; logic [15:0] sum_a, count_a;
  logic ready_b, vo_b; logic [7:0]  sum_b; logic [15:0] count_b;
  logic ready_c, vo_c; logic [15:0] sum_c, count_c;

  logic ready_m, vo_m;
  logic [15:0] sum_m, count_m;

  int n_vec = 0;
  int n_err = 0;
  int reduce_total = 0;

  always #5 clk = ~clk;

  bsg_adder_wallace_tree_sum_seq #(.width_p(16), .capacity_p(8), .count_width_p(16)) u_dut (
    .clk_i(clk), .reset_i(rst), .v_i(v && sel == 0), .data_i(data), .last_i(last),
    .ready_o(ready_a), .v_o(vo_a), .sum_o(sum_a), .count_o(count_a), .yumi_i(yumi && sel == 0)
  );

  bsg_adder_wallace_tree_sum_seq #(.width_p(8), .capacity_p(32), .count_width_p(16)) u_dut32 (
    .clk_i(clk), .reset_i(rst), .v_i(v && sel == 1), .data_i(data[7:0]), .last_i(last),
    .ready_o(ready_b), .v_o(vo_b), .sum_o(sum_b), .count_o(count_b), .yumi_i(yumi && sel == 1)
  );

  bsg_adder_wallace_tree_sum_seq #(.width_p(16), .capacity_p(16), .count_width_p(16)) u_dut16 (
    .clk_i(clk), .reset_i(rst), .v_i(v && sel == 2), .data_i(data), .last_i(last),
    .ready_o(ready_c), .v_o(vo_c), .sum_o(sum_c), .count_o(count_c), .yumi_i(yumi && sel == 2)
  );

  // Route the selected instance's outputs to common observation signals.
  always_comb begin
    ready_m = 1'b0; vo_m = 1'b0; sum_m = '0; count_m = '0;
    case (sel)
      0: begin ready_m = ready_a; vo_m = vo_a; sum_m = sum_a;          count_m = count_a; end
      1: begin ready_m = ready_b; vo_m = vo_b; sum_m = {8'h00, sum_b}; count_m = count_b; end
      2: begin ready_m = ready_c; vo_m = vo_c; sum_m = sum_c;          count_m = count_c; end
      default: ;
    endcase
  end

  // Count cycles the selected instance spends neither accepting nor presenting.
  always @(posedge clk) begin
    if (!rst && !ready_m && !vo_m) reduce_total <= reduce_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic beat(input logic [15:0] d, input logic l);
    int w = 0;
    while (!ready_m && w < 50) begin @(negedge clk); w++; end
    check("beat_ready", ready_m, 1);
    v = 1'b1; data = d; last = l;
    @(negedge clk);
    v = 1'b0; last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int w = 0;
    while (!vo_m && w < 100) begin @(negedge clk); w++; end
    check(tag, vo_m, 1);
  endtask

  task automatic consume();
    yumi = 1'b1;
    @(negedge clk);
    yumi = 1'b0;
    check("consume_ready", ready_m, 1);
    check("consume_vo", vo_m, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, sent, bubbles, cyc;
    sel = 0; v = 0; last = 0; yumi = 0; data = '0; rst = 1'b1;

    // Reset state
    #1;
    check("rst_ready", ready_m, 1);
    check("rst_vo", vo_m, 0);
    check("rst_sum", sum_m, 0);
    check("rst_count", count_m, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // 1: beats 1..8, last on 8th
    base = reduce_total;
    for (int i = 1; i <= 8; i++) beat(16'(i), i == 8);
    check("t1_reduce_ready", ready_m, 0);
    check("t1_reduce_vo", vo_m, 0);
    @(negedge clk);
    check("t1_latency_vo", vo_m, 1);
    check("t1_sum", sum_m, 36);
    check("t1_count", count_m, 8);
    check("t1_reduces", reduce_total - base, 1);
    consume();

    // 2: partial batch of three
    beat(16'd100, 1'b0); beat(16'd200, 1'b0); beat(16'd300, 1'b1);
    wait_done("t2_vo");
    check("t2_sum", sum_m, 600);
    check("t2_count", count_m, 3);
    consume();

    // 3: 20 beats of 0xFFFF with v held high
    base = reduce_total; sent = 0; bubbles = 0; cyc = 0;
    v = 1'b1; data = 16'hFFFF;
    while (sent < 20 && cyc < 200) begin
      last = (sent == 19);
      if (ready_m) sent++;
      else begin
        bubbles++;
        check("t3_bubble_pos", sent, (bubbles == 1) ? 8 : 16);
      end
      @(negedge clk); cyc++;
    end
    v = 1'b0; last = 1'b0;
    check("t3_sent", sent, 20);
    check("t3_bubbles", bubbles, 2);
    check("t3_final_reduce", {ready_m, vo_m}, 2'b00);
    @(negedge clk);
    check("t3_vo", vo_m, 1);
    check("t3_sum", sum_m, 16'hFFEC);
    check("t3_count", count_m, 20);
    check("t3_reduces", reduce_total - base, 3);

    // 4: hold DONE without yumi while offering operands
    v = 1'b1; data = 16'h5555;
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_sum", sum_m, 16'hFFEC);
      check("t4_hold_count", count_m, 20);
      check("t4_hold_ready", ready_m, 0);
      check("t4_hold_vo", vo_m, 1);
      @(negedge clk);
    end
    v = 1'b0;
    consume();
    beat(16'h0007, 1'b1);
    wait_done("t4_vo");
    check("t4_sum", sum_m, 16'h0007);
    check("t4_count", count_m, 1);
    consume();

    // 5: asynchronous reset during REDUCE, then during DONE
    for (int i = 0; i < 8; i++) beat(16'h00FF, 1'b0);
    beat(16'h00FF, 1'b1);
    check("t5_in_reduce", {ready_m, vo_m}, 2'b00);
    check("t5_acc_before", sum_m, 16'h07F8);
    rst = 1'b1;
    #1;
    check("t5_rst_vo", vo_m, 0);
    check("t5_rst_sum", sum_m, 0);
    check("t5_rst_ready", ready_m, 1);
    check("t5_rst_count", count_m, 0);
    @(negedge clk); rst = 1'b0;
    beat(16'h0002, 1'b1);
    wait_done("t5_vo");
    check("t5_sum", sum_m, 16'h0002);
    check("t5_count", count_m, 1);
    rst = 1'b1;
    #1;
    check("t5_done_rst_vo", vo_m, 0);
    check("t5_done_rst_sum", sum_m, 0);
    @(negedge clk); rst = 1'b0;
    check("t5_done_rst_ready", ready_m, 1);

    // 6a: capacity 32, width 8, 32 beats of 0x10
    @(negedge clk);
    sel = 1;
    base = reduce_total;
    for (int i = 1; i <= 32; i++) beat(16'h0010, i == 32);
    wait_done("t6a_vo");
    check("t6a_sum", sum_m, 16'h0000);
    check("t6a_count", count_m, 32);
    check("t6a_reduces", reduce_total - base, 1);
    consume();

    // 6b: capacity 16, 17 beats 1..17
    sel = 2;
    base = reduce_total;
    for (int i = 1; i <= 17; i++) beat(16'(i), i == 17);
    wait_done("t6b_vo");
    check("t6b_sum", sum_m, 153);
    check("t6b_count", count_m, 17);
    check("t6b_reduces", reduce_total - base, 2);
    consume();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
